jar_sram_driver: RTL and testbench

- Host-side sequencer directly upstream of the 8-pin nibble SRAM macro.
- Accepts byte-wide read/write requests on a valid/ready handshake and generates the SRAM pin sequence: nibble bus, oe, we, rst and a software-generated SRAM clock.
- Returns read data and write completions on a single-cycle response strobe.
- Lets on-chip logic or a test harness use the SRAM without hand-toggling pins.

---
 rtl/jar_sram_driver.sv | 194 +++++++++++++++++++
 tb/tb_jar_sram_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/jar_sram_driver.sv
// jar_sram_driver: host-side sequencer for the 8-pin nibble SRAM macro.
// Turns byte-wide read/write requests into SRAM pin sequences (nibble bus,
// oe, we, rst and a software-generated SRAM clock). Each request completes
// with a one-cycle response strobe. Every output comes straight from a flop.
module jar_sram_driver #(
  parameter int unsigned SETUP_CYCLES = 32'd1,
  parameter int unsigned HIGH_CYCLES  = 32'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [7:0] sram_pins,
  input  logic [7:0] sram_dout
);

  // One down-counter times both the setup (clock low) and high phases.
  localparam int unsigned MAX_CYC = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 32'd1) ? $clog2(MAX_CYC) : 32'd1;
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(HIGH_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);

  typedef enum logic [2:0] {
    INIT_S  = 3'd0,
    IDLE_S  = 3'd1,
    W_LO_S  = 3'd2,
    W_HI_S  = 3'd3,
    W_AD_S  = 3'd4,
    R_AD_S  = 3'd5,
    R_CAP_S = 3'd6
  } state_t;

  // Pin image for a given state/phase: {nibble[3:0], oe, we, rst, sram_clk}.
  function automatic logic [7:0] pins_for(
    input state_t     st,
    input logic       high,
    input logic [2:0] addr,
    input logic [7:0] wdata
  );
    logic [7:0] p;
    case (st)
      INIT_S:  p = {4'h0, 1'b0, 1'b0, 1'b1, high};
      IDLE_S:  p = 8'h00;
      W_LO_S:  p = {wdata[3:0], 1'b0, 1'b1, 1'b0, high};
      W_HI_S:  p = {wdata[7:4], 1'b0, 1'b1, 1'b0, high};
      W_AD_S:  p = {1'b0, addr, 1'b0, 1'b1, 1'b0, high};
      R_AD_S:  p = {1'b0, addr, 1'b1, 1'b0, 1'b0, high};
      R_CAP_S: p = {1'b0, addr, 1'b1, 1'b0, 1'b0, 1'b0};
      default: p = 8'h00;
    endcase
    return p;
  endfunction

  state_t           r_state;
  logic             r_high;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_addr;
  logic [7:0]       r_wdata;
  logic [7:0]       r_pins;
  logic             r_ready;
  logic             r_rsp_valid;
  logic [7:0]       r_rdata;

  state_t           w_state_nxt;
  logic             w_high_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_addr_nxt;
  logic [7:0]       w_wdata_nxt;
  logic             w_edge_done;
  logic             w_accept;
  logic [7:0]       w_pins_nxt;
  logic             w_rsp_valid_nxt;
  logic [7:0]       w_rdata_nxt;

  // Next-state logic: SRAM edge timing, request acceptance and sequencing.
  always_comb begin
    w_state_nxt = r_state;
    w_high_nxt  = r_high;
    w_cnt_nxt   = r_cnt;
    w_edge_done = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      INIT_S, W_LO_S, W_HI_S, W_AD_S, R_AD_S: begin
        if (r_cnt != CNT_ZERO) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (!r_high) begin
          w_high_nxt = 1'b1;
          w_cnt_nxt  = HIGH_LOAD;
        end else begin
          w_edge_done = 1'b1;
          w_high_nxt  = 1'b0;
          w_cnt_nxt   = SETUP_LOAD;
        end
        if (w_edge_done) begin
          case (r_state)
            INIT_S:  w_state_nxt = IDLE_S;
            W_LO_S:  w_state_nxt = W_HI_S;
            W_HI_S:  w_state_nxt = W_AD_S;
            W_AD_S:  w_state_nxt = IDLE_S;
            R_AD_S:  w_state_nxt = R_CAP_S;
            default: w_state_nxt = INIT_S;
          endcase
        end else begin
          w_state_nxt = r_state;
        end
      end
      IDLE_S: begin
        w_high_nxt = 1'b0;
        w_cnt_nxt  = SETUP_LOAD;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = req_we ? W_LO_S : R_AD_S;
        end else begin
          w_state_nxt = IDLE_S;
        end
      end
      R_CAP_S: begin
        w_state_nxt = IDLE_S;
        w_high_nxt  = 1'b0;
        w_cnt_nxt   = SETUP_LOAD;
      end
      default: begin
        w_state_nxt = INIT_S;
        w_high_nxt  = 1'b0;
        w_cnt_nxt   = SETUP_LOAD;
      end
    endcase
  end

  // Request capture and output images for the next cycle.
  always_comb begin
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_rdata_nxt     = r_rdata;
    w_rsp_valid_nxt = 1'b0;
    if (w_accept) begin
      w_addr_nxt  = req_addr;
      w_wdata_nxt = req_wdata;
    end else begin
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
    end
    if (r_state == R_CAP_S) begin
      // SRAM output is taken as-is at the end of the capture cycle.
      w_rsp_valid_nxt = 1'b1;
      w_rdata_nxt     = sram_dout;
    end else if ((r_state == W_AD_S) && w_edge_done) begin
      w_rsp_valid_nxt = 1'b1;
      w_rdata_nxt     = 8'h00;
    end else begin
      w_rsp_valid_nxt = 1'b0;
      w_rdata_nxt     = r_rdata;
    end
    w_pins_nxt = pins_for(w_state_nxt, w_high_nxt, w_addr_nxt, w_wdata_nxt);
  end

  // State, timing and output registers; reset aborts any transaction at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT_S;
      r_high      <= 1'b0;
      r_cnt       <= SETUP_LOAD;
      r_addr      <= 3'd0;
      r_wdata     <= 8'h00;
      r_pins      <= 8'h02;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_high      <= w_high_nxt;
      r_cnt       <= w_cnt_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_pins      <= w_pins_nxt;
      r_ready     <= (w_state_nxt == IDLE_S);
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign sram_pins = r_pins;

endmodule

// File: tb/tb_jar_sram_driver.sv
// Bench for jar_sram_driver: per-cycle vector table on a default-timing
// instance backed by a small nibble-SRAM model, plus hand sequences for
// the reset abort and a SETUP_CYCLES=2 / HIGH_CYCLES=3 instance.
`timescale 1ns/1ps
module tb_jar_sram_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default timing
  logic       rst_n, vld, we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       rdy, rv;
  logic [7:0] rdata, pins, dout;

  // Instance 2: SETUP_CYCLES=2, HIGH_CYCLES=3
  logic       rst2_n, vld2, we2;
  logic [2:0] addr2;
  logic [7:0] wdata2;
  logic       rdy2, rv2;
  logic [7:0] rdata2, pins2, dout2;

  jar_sram_driver u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(vld), .req_ready(rdy), .req_we(we),
    .req_addr(addr), .req_wdata(wdata), .rsp_valid(rv), .rsp_rdata(rdata),
    .sram_pins(pins), .sram_dout(dout)
  );

  jar_sram_driver #(.SETUP_CYCLES(2), .HIGH_CYCLES(3)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .req_valid(vld2), .req_ready(rdy2), .req_we(we2),
    .req_addr(addr2), .req_wdata(wdata2), .rsp_valid(rv2), .rsp_rdata(rdata2),
    .sram_pins(pins2), .sram_dout(dout2)
  );

  // Nibble SRAM model for instance 1: lo, hi, then address on write edges.
  logic [7:0] mem [0:7];
  logic [1:0] trk;
  logic [3:0] lo_n, hi_n;
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    trk = 2'd0; lo_n = 4'h0; hi_n = 4'h0;
  end
  always @(posedge pins[0]) begin
    if (pins[1]) begin
      trk <= 2'd0;
    end else if (pins[2]) begin
      case (trk)
        2'd0: begin lo_n <= pins[7:4]; trk <= 2'd1; end
        2'd1: begin hi_n <= pins[7:4]; trk <= 2'd2; end
        default: begin mem[pins[6:4]] <= {hi_n, lo_n}; trk <= 2'd0; end
      endcase
    end
  end
  assign dout  = pins[3]  ? mem[pins[6:4]] : 8'h00;
  assign dout2 = pins2[3] ? 8'h96 : 8'h00;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic       rst_n;
    logic       vld;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] pins;
    logic       rdy;
    logic       rv;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic w, input logic [2:0] a,
                     input logic [7:0] d, input logic [7:0] p, input logic rd,
                     input logic rsp, input logic [7:0] q);
    tbl.push_back({r, v, w, a, d, p, rd, rsp, q});
  endtask

  logic [7:0] w2_exp [0:15];
  logic [7:0] r2_exp [0:6];
  logic [7:0] i2_exp [0:4];
  bit         got;

  initial begin
    rst_n = 1'b0; vld = 1'b0; we = 1'b0; addr = 3'd0; wdata = 8'h00;
    rst2_n = 1'b0; vld2 = 1'b0; we2 = 1'b0; addr2 = 3'd0; wdata2 = 8'h00;

    // rst vld we addr wdata | pins rdy rv rdata
    add(0,0,0,3'd0,8'h00, 8'h02,0,0,8'h00);
    add(0,0,0,3'd0,8'h00, 8'h02,0,0,8'h00);
    add(1,0,0,3'd0,8'h00, 8'h03,0,0,8'h00);
    add(1,0,0,3'd0,8'h00, 8'h00,1,0,8'h00);
    add(1,1,1,3'd5,8'hA7, 8'h74,0,0,8'h00);   // write 5 <- A7
    add(1,1,0,3'd3,8'hFF, 8'h75,0,0,8'h00);   // busy: request ignored
    add(1,1,1,3'd6,8'h11, 8'hA4,0,0,8'h00);   // busy: request ignored
    add(1,0,0,3'd0,8'h00, 8'hA5,0,0,8'h00);
    add(1,0,0,3'd0,8'h00, 8'h54,0,0,8'h00);
    add(1,1,0,3'd2,8'h00, 8'h55,0,0,8'h00);   // busy: request ignored
    add(1,0,0,3'd0,8'h00, 8'h00,1,1,8'h00);   // write completion
    add(1,1,0,3'd5,8'h00, 8'h58,0,0,8'h00);   // read 5, back-to-back
    add(1,0,0,3'd0,8'h00, 8'h59,0,0,8'h00);
    add(1,0,0,3'd0,8'h00, 8'h58,0,0,8'h00);   // capture cycle
    add(1,0,0,3'd0,8'h00, 8'h00,1,1,8'hA7);
    add(1,0,0,3'd0,8'h00, 8'h00,1,0,8'hA7);   // rdata holds
    add(1,1,1,3'd2,8'h3C, 8'hC4,0,0,8'hA7);   // write 2 <- 3C
    add(1,0,0,3'd0,8'h00, 8'hC5,0,0,8'hA7);
    add(1,0,0,3'd0,8'h00, 8'h34,0,0,8'hA7);
    add(1,0,0,3'd0,8'h00, 8'h35,0,0,8'hA7);
    add(1,0,0,3'd0,8'h00, 8'h24,0,0,8'hA7);
    add(1,0,0,3'd0,8'h00, 8'h25,0,0,8'hA7);
    add(1,0,0,3'd0,8'h00, 8'h00,1,1,8'h00);
    add(1,1,0,3'd2,8'h00, 8'h28,0,0,8'h00);   // read 2 while rsp_valid high
    add(1,0,0,3'd0,8'h00, 8'h29,0,0,8'h00);
    add(1,0,0,3'd0,8'h00, 8'h28,0,0,8'h00);
    add(1,0,0,3'd0,8'h00, 8'h00,1,1,8'h3C);
    add(1,0,0,3'd0,8'h00, 8'h00,1,0,8'h3C);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; vld = tbl[i].vld; we = tbl[i].we;
      addr = tbl[i].addr; wdata = tbl[i].wdata;
      @(posedge clk); #1;
      chk($sformatf("v%0d pins", i), pins, tbl[i].pins);
      chk($sformatf("v%0d ready", i), {7'd0, rdy}, {7'd0, tbl[i].rdy});
      chk($sformatf("v%0d rsp_valid", i), {7'd0, rv}, {7'd0, tbl[i].rv});
      chk($sformatf("v%0d rdata", i), rdata, tbl[i].rdata);
    end

    // Abort: reset during the W_HI phase of write 1 <- 55
    vld = 1'b1; we = 1'b1; addr = 3'd1; wdata = 8'h55;
    @(posedge clk); #1; vld = 1'b0;
    chk("abort wlo setup", pins, 8'h54);
    @(posedge clk); #1; chk("abort wlo high", pins, 8'h55);
    @(posedge clk); #1; chk("abort whi setup", pins, 8'h54);
    rst_n = 1'b0; #1;
    chk("abort pins async", pins, 8'h02);
    chk("abort ready", {7'd0, rdy}, 8'h00);
    chk("abort rsp_valid", {7'd0, rv}, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("abort held pins", pins, 8'h02);
      chk("abort held rsp_valid", {7'd0, rv}, 8'h00);
    end
    rst_n = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      chk("reinit rsp_valid", {7'd0, rv}, 8'h00);
      got = rdy;
    end
    chk("reinit ready reached", {7'd0, got}, 8'h01);
    vld = 1'b1; we = 1'b0; addr = 3'd1;
    @(posedge clk); #1; vld = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      got = rv;
    end
    chk("abort read rsp", {7'd0, got}, 8'h01);
    chk("abort read data", rdata, 8'h00);

    // Stretched timing instance: init, write 2 <- 3C, read 3 back-to-back
    i2_exp = '{8'h02, 8'h03, 8'h03, 8'h03, 8'h00};
    w2_exp = '{8'hC4, 8'hC4, 8'hC5, 8'hC5, 8'hC5, 8'h34, 8'h34, 8'h35,
               8'h35, 8'h35, 8'h24, 8'h24, 8'h25, 8'h25, 8'h25, 8'h00};
    r2_exp = '{8'h38, 8'h38, 8'h39, 8'h39, 8'h39, 8'h38, 8'h00};
    @(posedge clk); #1;
    chk("s2 reset pins", pins2, 8'h02);
    rst2_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("s2 init c%0d pins", k), pins2, i2_exp[k]);
      chk($sformatf("s2 init c%0d ready", k), {7'd0, rdy2}, {7'd0, (k == 4)});
    end
    vld2 = 1'b1; we2 = 1'b1; addr2 = 3'd2; wdata2 = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      vld2 = 1'b0;
      chk($sformatf("s2 wr c%0d pins", k), pins2, w2_exp[k]);
      chk($sformatf("s2 wr c%0d rsp_valid", k), {7'd0, rv2}, {7'd0, (k == 15)});
    end
    chk("s2 wr rdata", rdata2, 8'h00);
    vld2 = 1'b1; we2 = 1'b0; addr2 = 3'd3;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      vld2 = 1'b0;
      chk($sformatf("s2 rd c%0d pins", k), pins2, r2_exp[k]);
      chk($sformatf("s2 rd c%0d rsp_valid", k), {7'd0, rv2}, {7'd0, (k == 6)});
    end
    chk("s2 rd rdata", rdata2, 8'h96);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
